// File: rtl/circuit1_operand_loader.sv
// Operand loader for the Circuit1 datapath: collects a, b, c words over a
// valid/ready handshake, holds the completed triplet for HOLD_CYCLES cycles and
// pulses `sample` when the datapath outputs must be latched downstream.
//
// state  | meaning
// LOAD_A | waiting for the a word
// LOAD_B | waiting for the b word
// LOAD_C | waiting for the c word
// HOLD   | triplet complete, op_valid high, counting down to sample
module circuit1_operand_loader #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic                 op_valid,
  output logic                 sample,
  output logic [CNT_WIDTH-1:0] triplet_cnt
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_C = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [HCW-1:0] hold_cnt;
  logic           xfer;
  logic           ld_a, ld_b, ld_c;

  // Next-state decode, handshake and load strobes
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    sample     = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_c       = 1'b0;
    xfer       = 1'b0;
    if (state != HOLD) begin
      in_ready = !flush;
    end
    xfer = in_valid && in_ready;
    case (state)
      LOAD_A: begin
        if (xfer) begin
          ld_a       = 1'b1;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (flush) begin
          state_next = LOAD_A;
        end else if (xfer) begin
          ld_b       = 1'b1;
          state_next = LOAD_C;
        end
      end
      LOAD_C: begin
        if (flush) begin
          state_next = LOAD_A;
        end else if (xfer) begin
          ld_c       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next = LOAD_A;
        end else if (hold_cnt == '0) begin
          sample     = 1'b1;
          state_next = LOAD_A;
        end
      end
      default: state_next = LOAD_A;
    endcase
  end

  // State, hold timer, operand registers and triplet counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= LOAD_A;
      hold_cnt    <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      op_valid    <= 1'b0;
      triplet_cnt <= '0;
    end else begin
      state    <= state_next;
      op_valid <= (state_next == HOLD);
      if (ld_a) a <= in_data;
      if (ld_b) b <= in_data;
      if (ld_c) begin
        c        <= in_data;
        hold_cnt <= HOLD_LOAD;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HCW'(1);
      end
      if (sample) triplet_cnt <= triplet_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_circuit1_operand_loader.sv
// Bench for circuit1_operand_loader: directed scenarios plus random traffic,
// all outputs compared every cycle against a word-collecting reference model.
// A second instance with a 4-bit counter shares the stimulus to reach the wrap.
module tb_circuit1_operand_loader;

  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [WIDTH-1:0] in_data = 8'hAA;
  logic             in_valid = 1'b1;
  logic             flush = 1'b0;
  logic             in_ready, op_valid, sample;
  logic [WIDTH-1:0] a, b, c;
  logic [15:0]      triplet_cnt;
  logic             in_ready_w, op_valid_w, sample_w;
  logic [WIDTH-1:0] a_w, b_w, c_w;
  logic [3:0]       triplet_cnt_w;

  circuit1_operand_loader #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .CNT_WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .a(a), .b(b), .c(c), .op_valid(op_valid), .sample(sample),
    .triplet_cnt(triplet_cnt));

  circuit1_operand_loader #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .CNT_WIDTH(4)) dut_w (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w),
    .flush(flush), .a(a_w), .b(b_w), .c(c_w), .op_valid(op_valid_w), .sample(sample_w),
    .triplet_cnt(triplet_cnt_w));

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: words collected so far, hold time remaining, counters
  logic [WIDTH-1:0] m_w [3];
  int               m_n = 0;
  bit               m_hold = 0;
  int               m_rem = 0;
  int               m_cnt = 0;
  bit               m_ok = 0;

  always @(posedge Clk) begin
    if (Rst) begin
      m_w[0] = '0; m_w[1] = '0; m_w[2] = '0;
      m_n = 0; m_hold = 0; m_rem = 0; m_cnt = 0; m_ok = 1;
    end else if (m_ok) begin
      if (m_hold) begin
        if (flush) begin
          m_hold = 0;
        end else if (m_rem == 1) begin
          m_hold = 0;
          m_cnt  = m_cnt + 1;
        end else begin
          m_rem = m_rem - 1;
        end
      end else if (flush) begin
        m_n = 0;
      end else if (in_valid) begin
        m_w[m_n] = in_data;
        m_n = m_n + 1;
        if (m_n == 3) begin
          m_n = 0; m_hold = 1; m_rem = HOLD;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge Clk) begin
    if (m_ok) begin
      chk("in_ready", in_ready, !m_hold && !flush);
      chk("sample", sample, m_hold && m_rem == 1 && !flush);
      chk("op_valid", op_valid, m_hold);
      chk("a", a, m_w[0]);
      chk("b", b, m_w[1]);
      chk("c", c, m_w[2]);
      chk("triplet_cnt", triplet_cnt, 32'(m_cnt % 65536));
      chk("triplet_cnt_w", triplet_cnt_w, 32'(m_cnt % 16));
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clk);
      if (in_ready) done = 1;
      step();
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    bit done = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Clk);
      if (in_ready) done = 1;
      else step();
    end
    if (!done) chk("ready_timeout", 0, 1);
    step();
  endtask

  task automatic triplet(input logic [WIDTH-1:0] x0, x1, x2);
    send(x0); send(x1); send(x2);
    wait_ready();
  endtask

  initial begin
    // T1 reset with in_valid high
    step(); step();
    @(negedge Clk);
    chk("t1_a", a, 0); chk("t1_op_valid", op_valid, 0);
    chk("t1_sample", sample, 0); chk("t1_cnt", triplet_cnt, 0);
    Rst = 1'b0; in_valid = 1'b0;
    step();
    @(negedge Clk);
    chk("t1_in_ready", in_ready, 1);
    step();

    // T2 back-to-back words
    send(8'h05); send(8'h03); send(8'h02);
    in_valid = 1'b0;
    @(negedge Clk);
    chk("t2_ov1", op_valid, 1); chk("t2_s1", sample, 0);
    step(); @(negedge Clk);
    chk("t2_ov2", op_valid, 1); chk("t2_s2", sample, 1);
    step(); @(negedge Clk);
    chk("t2_ov3", op_valid, 0);
    chk("t2_a", a, 8'h05); chk("t2_b", b, 8'h03); chk("t2_c", c, 8'h02);
    chk("t2_cnt", triplet_cnt, 1);
    step();

    // T3 bubbles between words
    send(8'h05); in_valid = 1'b0; repeat (3) step();
    send(8'h03); in_valid = 1'b0; repeat (3) step();
    send(8'h02); wait_ready();
    chk("t3_c", c, 8'h02); chk("t3_cnt", triplet_cnt, 2);

    // T4 flush of a partial triplet
    send(8'h11); send(8'h22);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    @(negedge Clk);
    chk("t4_ready_in_flush", in_ready, 0);
    step(); flush = 1'b0; in_valid = 1'b0;
    triplet(8'h01, 8'h02, 8'h03);
    chk("t4_a", a, 8'h01); chk("t4_b", b, 8'h02); chk("t4_c", c, 8'h03);
    chk("t4_cnt", triplet_cnt, 3);

    // T5 flush in the first hold cycle
    send(8'h07); send(8'h08); send(8'h09);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge Clk);
    chk("t5_no_sample", sample, 0);
    step(); flush = 1'b0;
    @(negedge Clk);
    chk("t5_ov", op_valid, 0); chk("t5_ready", in_ready, 1); chk("t5_cnt", triplet_cnt, 3);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      Rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 6);
      in_data  = 8'($urandom);
      flush    = ($urandom_range(0, 19) == 0);
      step();
    end

    // T6 counter wrap on the 4-bit instance, then reset in the middle of a hold
    Rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    step(); Rst = 1'b0; step();
    for (int i = 0; i < 16; i++) triplet(8'(i), 8'(i + 1), 8'(i + 2));
    chk("t6_wrap_w", triplet_cnt_w, 0);
    chk("t6_cnt", triplet_cnt, 16);
    send(8'hA1); send(8'hB2); send(8'hC3);
    in_valid = 1'b0; Rst = 1'b1;
    @(negedge Clk);
    chk("t6_hold_ov", op_valid, 1);
    step(); Rst = 1'b0;
    @(negedge Clk);
    chk("t6_rst_ov", op_valid, 0); chk("t6_rst_sample", sample, 0);
    chk("t6_rst_a", a, 0); chk("t6_rst_c", c, 0); chk("t6_rst_cnt", triplet_cnt, 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
